condicionador_jogada: RTL and testbench

//  Input conditioner directly upstream of the game core's jogada[5:0] input.
//  - Synchronises and debounces the six raw board buttons.
//  - Edge-detects each button: one press gives one single-cycle pulse.
//  - Arbitrates the movement group to at most one direction per cycle.

---
 rtl/condicionador_jogada_pkg.sv | 54 +++++
 rtl/condicionador_jogada_if.sv | 29 ++
 rtl/condicionador_jogada_debounce_botao.sv | 50 +++++
 rtl/condicionador_jogada.sv | 165 ++++++++++++++++
 tb/tb_condicionador_jogada.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/condicionador_jogada_pkg.sv
// Shared definitions for the jogada input conditioner and for the game core
// datapath that consumes jogada[5:0]: button bit indices, the auto-repeat
// state encoding and the movement priority helpers.
package condicionador_jogada_pkg;

  localparam int N_BOTOES    = 6;
  localparam int N_MOV       = 4;

  localparam int JOG_UP      = 0;
  localparam int JOG_DOWN    = 1;
  localparam int JOG_LEFT    = 2;
  localparam int JOG_RIGHT   = 3;
  localparam int JOG_SPECIAL = 4;
  localparam int JOG_SHOT    = 5;

  // Auto-repeat FSM encoding (only used when AUTO_REPEAT_EN is defined)
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    REPETE = 2'd2
  } estado_rep_t;

  // Keep only the lowest-index movement rise: up > down > left > right.
  function automatic logic [3:0] prioridade_mov(input logic [3:0] subida);
    logic [3:0] escolhido;
    escolhido = 4'b0000;
    if (subida[JOG_UP]) begin
      escolhido[JOG_UP] = 1'b1;
    end else if (subida[JOG_DOWN]) begin
      escolhido[JOG_DOWN] = 1'b1;
    end else if (subida[JOG_LEFT]) begin
      escolhido[JOG_LEFT] = 1'b1;
    end else if (subida[JOG_RIGHT]) begin
      escolhido[JOG_RIGHT] = 1'b1;
    end else begin
      escolhido = 4'b0000;
    end
    return escolhido;
  endfunction

  // Index of a one-hot movement vector (0 when empty).
  function automatic logic [1:0] indice_mov(input logic [3:0] one_hot);
    logic [1:0] idx;
    case (one_hot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/condicionador_jogada_if.sv
// Button/jogada bus between the board side and the conditioner.
// master: board/bench side driving raw buttons and the enable.
// slave : conditioner side producing pulses and debounced levels.
interface condicionador_jogada_if;
  import condicionador_jogada_pkg::*;

  logic [N_BOTOES-1:0] botoes;
  logic                habilita;
  logic [N_BOTOES-1:0] jogada;
  logic                jogada_valida;
  logic [N_BOTOES-1:0] db_estavel;

  modport master (
    output botoes,
    output habilita,
    input  jogada,
    input  jogada_valida,
    input  db_estavel
  );

  modport slave (
    input  botoes,
    input  habilita,
    output jogada,
    output jogada_valida,
    output db_estavel
  );

endinterface

// File: rtl/condicionador_jogada_debounce_botao.sv
// One button: 2-flop synchroniser, consecutive-stability counter and the
// accepted (stable) level. The level only flips after DEBOUNCE_CYCLES
// consecutive samples that disagree with it.
module condicionador_jogada_debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_bruto,
  output logic estavel
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sinc_q, sinc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          estavel_q, estavel_d;

  // Next-state: shift synchroniser, count disagreement, flip at the limit.
  always_comb begin
    sinc_d    = {sinc_q[0], botao_bruto};
    cnt_d     = cnt_q;
    estavel_d = estavel_q;
    if (sinc_q[1] == estavel_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMITE) begin
      estavel_d = ~estavel_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_q    <= 2'b00;
      cnt_q     <= '0;
      estavel_q <= 1'b0;
    end else begin
      sinc_q    <= sinc_d;
      cnt_q     <= cnt_d;
      estavel_q <= estavel_d;
    end
  end

  assign estavel = estavel_q;

endmodule

// File: rtl/condicionador_jogada.sv
// Input conditioner upstream of the game core's jogada[5:0] input:
// debounce per button, rising-edge detection, movement arbitration,
// habilita masking and a registered single-cycle pulse output.
// Optional feature: define AUTO_REPEAT_EN to add the held-direction
// auto-repeat FSM (OCIOSO/ESPERA/REPETE). Without it a held button gives
// exactly one pulse.
module condicionador_jogada
  import condicionador_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_DELAY  = 25000000
  , parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  condicionador_jogada_if.slave  bus
);

  logic [N_BOTOES-1:0] estavel_s;
  logic [N_BOTOES-1:0] estavel_ant_q, estavel_ant_d;
  logic [N_BOTOES-1:0] subida_s;
  logic [N_MOV-1:0]    mov_s;
  logic [N_MOV-1:0]    mov_fim_s;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                valida_q, valida_d;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_db
    condicionador_jogada_debounce_botao #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock       (clock),
      .reset       (reset),
      .botao_bruto (bus.botoes[i]),
      .estavel     (estavel_s[i])
    );
  end

  // Rising edges of the debounced levels and movement arbitration.
  always_comb begin
    estavel_ant_d = estavel_s;
    subida_s      = estavel_s & ~estavel_ant_q;
    mov_s         = prioridade_mov(subida_s[JOG_RIGHT:JOG_UP]);
  end

`ifdef AUTO_REPEAT_EN
  localparam int            RW      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] LIM_ATR = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] LIM_PER = RW'(REPEAT_PERIOD - 1);

  estado_rep_t   estado_q, estado_d;
  logic [1:0]    dir_q, dir_d;
  logic [RW-1:0] cnt_rep_q, cnt_rep_d;
  logic [3:0]    rep_pulso_s;
  logic          mov_emit_s;

  // Repeat FSM: latch the emitted direction, wait, then repeat while held.
  // Only an emitted (unmasked) movement pulse arms the FSM, so a press
  // that was swallowed by habilita never starts repeating later.
  always_comb begin
    estado_d    = estado_q;
    dir_d       = dir_q;
    cnt_rep_d   = cnt_rep_q;
    rep_pulso_s = 4'b0000;
    mov_emit_s  = bus.habilita & (|mov_s);
    case (estado_q)
      OCIOSO: begin
        if (mov_emit_s) begin
          estado_d  = ESPERA;
          dir_d     = indice_mov(mov_s);
          cnt_rep_d = '0;
        end else begin
          cnt_rep_d = '0;
        end
      end
      ESPERA: begin
        if (mov_emit_s) begin
          estado_d  = ESPERA;
          dir_d     = indice_mov(mov_s);
          cnt_rep_d = '0;
        end else if (!estavel_s[dir_q]) begin
          estado_d  = OCIOSO;
          cnt_rep_d = '0;
        end else if (cnt_rep_q == LIM_ATR) begin
          estado_d    = REPETE;
          rep_pulso_s = 4'b0001 << dir_q;
          cnt_rep_d   = '0;
        end else begin
          cnt_rep_d = cnt_rep_q + RW'(1);
        end
      end
      REPETE: begin
        if (mov_emit_s) begin
          estado_d  = ESPERA;
          dir_d     = indice_mov(mov_s);
          cnt_rep_d = '0;
        end else if (!estavel_s[dir_q]) begin
          estado_d  = OCIOSO;
          cnt_rep_d = '0;
        end else if (cnt_rep_q == LIM_PER) begin
          rep_pulso_s = 4'b0001 << dir_q;
          cnt_rep_d   = '0;
        end else begin
          cnt_rep_d = cnt_rep_q + RW'(1);
        end
      end
      default: begin
        estado_d  = OCIOSO;
        cnt_rep_d = '0;
      end
    endcase
    mov_fim_s = (|mov_s) ? mov_s : rep_pulso_s;
  end

  // Repeat FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      dir_q     <= 2'd0;
      cnt_rep_q <= '0;
    end else begin
      estado_q  <= estado_d;
      dir_q     <= dir_d;
      cnt_rep_q <= cnt_rep_d;
    end
  end
`else
  // Without auto-repeat only fresh movement rises reach the output.
  always_comb begin
    mov_fim_s = mov_s;
  end
`endif

  // Output mask: attack bits pass independently, habilita gates everything.
  always_comb begin
    jogada_d = '0;
    if (bus.habilita) begin
      jogada_d[JOG_RIGHT:JOG_UP] = mov_fim_s;
      jogada_d[JOG_SPECIAL]      = subida_s[JOG_SPECIAL];
      jogada_d[JOG_SHOT]         = subida_s[JOG_SHOT];
    end else begin
      jogada_d = '0;
    end
    valida_d = |jogada_d;
  end

  // Edge-detect history and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estavel_ant_q <= '0;
      jogada_q      <= '0;
      valida_q      <= 1'b0;
    end else begin
      estavel_ant_q <= estavel_ant_d;
      jogada_q      <= jogada_d;
      valida_q      <= valida_d;
    end
  end

  assign bus.jogada        = jogada_q;
  assign bus.jogada_valida = valida_q;
  assign bus.db_estavel    = estavel_s;

endmodule

// File: tb/tb_condicionador_jogada.sv
// Directed bench for condicionador_jogada with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expected pulses: press driven 1 time
// unit after edge 0 -> debounced level at edge 6 -> jogada at edge 7.
module tb_condicionador_jogada;
  import condicionador_jogada_pkg::*;

`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  condicionador_jogada_if bus ();

  condicionador_jogada #(
    .DEBOUNCE_CYCLES(4)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(10)
    , .REPEAT_PERIOD(3)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Movement pulse expected k cycles after the press, released after edge r:
  // first pulse at 7; with auto-repeat, one at 17 and every 3 after that,
  // as long as the debounced level (drops at edge r+6) was still high when
  // the pulse was decided.
  function automatic logic mov_esperado(input int k, input int r);
    if (k == 7) return 1'b1;
    if (REP && k >= 17 && k <= r + 6 && ((k - 17) % 3) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Press 'padrao' (already applied), check n cycles, release after edge r.
  task automatic janela(input string tag, input int bit_mov, input logic [5:0] extra,
                        input logic [5:0] padrao, input int r, input int n);
    logic [5:0] exp_j;
    logic [5:0] exp_db;
    for (int k = 1; k <= n; k++) begin
      ciclo();
      exp_j = 6'b000000;
      if (mov_esperado(k, r)) exp_j[bit_mov] = 1'b1;
      if (k == 7) exp_j = exp_j | extra;
      exp_db = (k >= 6 && k < r + 6) ? padrao : 6'b000000;
      chk({tag, "_jogada"}, bus.jogada, exp_j);
      chk({tag, "_valida"}, {5'b00000, bus.jogada_valida}, {5'b00000, |exp_j});
      chk({tag, "_db"}, bus.db_estavel, exp_db);
      if (k == r) bus.botoes = 6'b000000;
    end
  endtask

  task automatic quieto(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      ciclo();
      chk(tag, bus.jogada, 6'b000000);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.botoes   = 6'b000000;
    bus.habilita = 1'b1;

    // Reset state
    ciclo();
    ciclo();
    chk("rst_jogada", bus.jogada, 6'b000000);
    chk("rst_valida", {5'b00000, bus.jogada_valida}, 6'b000000);
    chk("rst_db", bus.db_estavel, 6'b000000);
    reset = 1'b1;
    ciclo();
    ciclo();

    // 1: hold up 20 cycles, one pulse at cycle 7, no pulse on release
    bus.botoes = 6'b000001;
    janela("t1", JOG_UP, 6'b000000, 6'b000001, 20, 30);
    quieto("t1_idle", 4);

    // 2: 2-high/2-low glitches never get through
    for (int k = 0; k < 30; k++) begin
      bus.botoes = ((k % 4) < 2) ? 6'b000001 : 6'b000000;
      ciclo();
      chk("t2_jogada", bus.jogada, 6'b000000);
      chk("t2_db", bus.db_estavel, 6'b000000);
    end
    bus.botoes = 6'b000000;
    quieto("t2_idle", 8);

    // 3: down+left+shot together -> down wins, shot passes alongside
    bus.botoes = 6'b100110;
    janela("t3", JOG_DOWN, 6'b100000, 6'b100110, 12, 20);
    quieto("t3_idle", 4);

    // 4: press right while masked, unmask while held -> never a pulse
    bus.habilita = 1'b0;
    bus.botoes   = 6'b001000;
    quieto("t4_masked", 10);
    bus.habilita = 1'b1;
    quieto("t4_unmasked", 10);
    chk("t4_db_held", bus.db_estavel, 6'b001000);
    bus.botoes = 6'b000000;
    quieto("t4_release", 10);
    chk("t4_db_rel", bus.db_estavel, 6'b000000);

    // 5: reset mid-press clears outputs at once; re-press works normally
    bus.botoes = 6'b000001;
    janela("t5a", JOG_UP, 6'b000000, 6'b000001, 100, 8);
    reset = 1'b0;
    #1;
    chk("t5_rst_jogada", bus.jogada, 6'b000000);
    chk("t5_rst_valida", {5'b00000, bus.jogada_valida}, 6'b000000);
    chk("t5_rst_db", bus.db_estavel, 6'b000000);
    ciclo();
    ciclo();
    chk("t5_rst_hold", bus.db_estavel, 6'b000000);
    bus.botoes = 6'b000000;
    ciclo();
    reset = 1'b1;
    quieto("t5_after", 10);
    bus.botoes = 6'b000001;
    janela("t5b", JOG_UP, 6'b000000, 6'b000001, 10, 18);

    // 6: long hold of up (repeats only with AUTO_REPEAT_EN)
    bus.botoes = 6'b000001;
    janela("t6", JOG_UP, 6'b000000, 6'b000001, 30, 42);
    quieto("t6_idle", 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
